// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: takes the rasterizer pixel stream, clips and dedupes it,
// buffers it in a small FIFO, and writes each pixel to the framebuffer SRAM
// with a SETUP / STROBE / HOLD write-strobe sequence.
//
// Ports:
//   clk, n_rst               clock, asynchronous active-low reset
//   pix_addr/pix_color       pixel {X[9:0],Y[8:0]} and colour from rasterizer
//   pix_valid                pixel valid this cycle
//   prim_done                rising edge marks end of primitive
//   stop                     backpressure to rasterizer (from registered count)
//   sram_addr/sram_wdata     framebuffer address / write data
//   sram_ce_n/sram_we_n      active-low chip enable / write enable
//   write_done               one-cycle pulse once the primitive is fully written
//   overflow                 sticky: pixel dropped because FIFO was full
//   pix_count                pixels written since last write_done (wraps)
module fb_pixel_writer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned WE_CYCLES = 2,
    parameter int unsigned H_RES     = 640,
    parameter int unsigned V_RES     = 480
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [18:0]        pix_addr,
    input  logic               pix_valid,
    input  logic [COLOR_W-1:0] pix_color,
    input  logic               prim_done,
    output logic               stop,
    output logic [18:0]        sram_addr,
    output logic [COLOR_W-1:0] sram_wdata,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               write_done,
    output logic               overflow,
    output logic [15:0]        pix_count
);

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned ENT_W  = ADDR_W + COLOR_W;
    localparam int unsigned WC_W   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic [WC_W-1:0]    we_cnt_q, we_cnt_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d, last_addr_q, last_addr_d;
    logic [COLOR_W-1:0] wdata_q, wdata_d;
    logic               ce_n_q, ce_n_d, we_n_q, we_n_d;
    logic               last_vld_q, last_vld_d;
    logic               done_pend_q, done_pend_d;
    logic               prim_done_q, prim_done_d;
    logic               write_done_q, write_done_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        pix_count_q, pix_count_d;

    logic               clip, dup, full, empty, pop, push, fire;
    logic [ENT_W-1:0]   head;

    // Acceptance qualifiers; a pop in the same cycle frees a slot for a push when full
    always_comb begin
        clip  = (32'(pix_addr[18:9]) >= H_RES) || (32'(pix_addr[8:0]) >= V_RES);
        dup   = last_vld_q && (pix_addr == last_addr_q);
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == '0);
        pop   = ((state_q == S_IDLE) || (state_q == S_HOLD)) && !empty;
        push  = pix_valid && !clip && !dup && (!full || pop);
        fire  = done_pend_q && empty && (state_q == S_IDLE);
        head  = mem_q[rd_ptr_q];
    end

    assign stop = (count_q >= CNT_W'(DEPTH - 2));

    // Next-state: FIFO, write FSM, completion tracking
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d      = state_q;
        we_cnt_d     = we_cnt_q;
        sram_addr_d  = sram_addr_q;
        wdata_d      = wdata_q;
        last_addr_d  = last_addr_q;
        last_vld_d   = last_vld_q;
        prim_done_d  = prim_done;
        done_pend_d  = done_pend_q;
        write_done_d = fire;
        overflow_d   = overflow_q;
        pix_count_d  = write_done_q ? 16'd0 : pix_count_q;

        if (push) begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            last_addr_d = pix_addr;
        end
        if (pix_valid && !clip && !dup && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            sram_addr_d = head[ENT_W-1:COLOR_W];
            wdata_d     = head[COLOR_W-1:0];
        end

        case (state_q)
            S_IDLE: begin
                if (pop) state_d = S_SETUP;
            end
            S_SETUP: begin
                state_d  = S_STROBE;
                we_cnt_d = '0;
            end
            S_STROBE: begin
                if (we_cnt_q == WC_W'(WE_CYCLES - 1)) state_d = S_HOLD;
                else                                   we_cnt_d = we_cnt_q + WC_W'(1);
            end
            default: begin
                pix_count_d = pix_count_d + 16'd1;
                state_d     = pop ? S_SETUP : S_IDLE;
            end
        endcase

        // Strobes registered from the next state so they line up with state_q
        ce_n_d = (state_d == S_IDLE);
        we_n_d = (state_d != S_STROBE);

        // A prim_done edge while already pending (or while firing) merges into one pulse
        if (fire)                                 done_pend_d = 1'b0;
        else if (prim_done && !prim_done_q)       done_pend_d = 1'b1;

        if (fire) last_vld_d = 1'b0;
        if (push) last_vld_d = 1'b1;
    end

    // FIFO storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pix_addr, pix_color};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            we_cnt_q     <= '0;
            sram_addr_q  <= '0;
            wdata_q      <= '0;
            ce_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            last_addr_q  <= '0;
            last_vld_q   <= 1'b0;
            prim_done_q  <= 1'b0;
            done_pend_q  <= 1'b0;
            write_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            pix_count_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            we_cnt_q     <= we_cnt_d;
            sram_addr_q  <= sram_addr_d;
            wdata_q      <= wdata_d;
            ce_n_q       <= ce_n_d;
            we_n_q       <= we_n_d;
            last_addr_q  <= last_addr_d;
            last_vld_q   <= last_vld_d;
            prim_done_q  <= prim_done_d;
            done_pend_q  <= done_pend_d;
            write_done_q <= write_done_d;
            overflow_q   <= overflow_d;
            pix_count_q  <= pix_count_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = wdata_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_we_n  = we_n_q;
    assign write_done = write_done_q;
    assign overflow   = overflow_q;
    assign pix_count  = pix_count_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: randomized and directed stimulus against a queue-based
// reference of which pixels must reach the SRAM, and in what order.
`timescale 1ns/1ps
module tb_fb_pixel_writer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned COLOR_W   = 8;
    localparam int unsigned WE_CYCLES = 2;
    localparam int unsigned H_RES     = 640;
    localparam int unsigned V_RES     = 480;
    localparam int          P         = WE_CYCLES + 2;

    logic               clk = 1'b0;
    logic               n_rst = 1'b0;
    logic [18:0]        pix_addr = '0;
    logic               pix_valid = 1'b0;
    logic [COLOR_W-1:0] pix_color = '0;
    logic               prim_done = 1'b0;
    logic               stop;
    logic [18:0]        sram_addr;
    logic [COLOR_W-1:0] sram_wdata;
    logic               sram_ce_n, sram_we_n, write_done, overflow;
    logic [15:0]        pix_count;

    always #5 clk = ~clk;

    fb_pixel_writer #(
        .DEPTH(DEPTH), .COLOR_W(COLOR_W), .WE_CYCLES(WE_CYCLES),
        .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .clk(clk), .n_rst(n_rst), .pix_addr(pix_addr), .pix_valid(pix_valid),
        .pix_color(pix_color), .prim_done(prim_done), .stop(stop),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ce_n(sram_ce_n),
        .sram_we_n(sram_we_n), .write_done(write_done), .overflow(overflow),
        .pix_count(pix_count)
    );

    typedef struct packed {
        logic [18:0]        addr;
        logic [COLOR_W-1:0] color;
    } pix_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    pix_t        exp_q[$];
    pix_t        mon_e;
    logic [18:0] m_last;
    bit          m_last_vld;
    int          m_expected;
    int          n_writes, n_done, run;
    logic [18:0] cap_addr;
    logic        we_prev = 1'b1;
    int          pushes, nxt, e, occ, first_occ, g, k, r;
    bit          got_done, stop_seen;
    logic [18:0] a, prev_a;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [18:0] mk(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    // Reference: clip, then dedupe against last accepted, else it must be written
    task automatic model_offer(input logic [18:0] ad, input logic [COLOR_W-1:0] c);
        int x, y;
        x = int'(ad[18:9]);
        y = int'(ad[8:0]);
        if (x >= int'(H_RES) || y >= int'(V_RES)) return;
        if (m_last_vld && ad == m_last) return;
        exp_q.push_back({ad, c});
        m_last     = ad;
        m_last_vld = 1'b1;
        m_expected++;
    endtask

    task automatic do_reset();
        pix_valid = 1'b0;
        prim_done = 1'b0;
        n_rst     = 1'b0;
        repeat (2) @(negedge clk);
        exp_q.delete();
        m_last_vld = 1'b0;
        m_expected = 0;
        n_writes   = 0;
        n_done     = 0;
        n_rst      = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; the pixel is sampled at the following posedge
    task automatic present(input logic [18:0] ad, input logic [COLOR_W-1:0] c, input bit honour);
        int w;
        w = 0;
        while (honour && stop && w < 1000) begin
            pix_valid = 1'b0;
            @(negedge clk);
            w++;
        end
        if (w >= 1000) check_eq("stop_stuck", 1, 0);
        pix_valid = 1'b1;
        pix_addr  = ad;
        pix_color = c;
        model_offer(ad, c);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || sram_ce_n !== 1'b1) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        check_eq({tag, "_drain_timeout"}, 32'(w < 2000), 1);
    endtask

    // SRAM write monitor: order/content, strobe length, address stability
    always @(negedge clk) begin
        if (!n_rst) begin
            run     = 0;
            we_prev = 1'b1;
        end else begin
            if (!sram_we_n) begin
                if (we_prev) begin
                    n_writes++;
                    cap_addr = sram_addr;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_write", 32'(sram_addr), 32'h7FFFF);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check_eq("wr_addr", 32'(sram_addr), 32'(mon_e.addr));
                        check_eq("wr_data", 32'(sram_wdata), 32'(mon_e.color));
                    end
                end
                check_eq("ce_during_we", 32'(sram_ce_n), 0);
                run++;
            end else if (!we_prev) begin
                check_eq("we_len", run, WE_CYCLES);
                check_eq("addr_stable", 32'(sram_addr), 32'(cap_addr));
                run = 0;
            end
            if (write_done) n_done++;
            we_prev = sram_we_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        do_reset();
        check_eq("rst_stop", 32'(stop), 0);
        check_eq("rst_ce_n", 32'(sram_ce_n), 1);
        check_eq("rst_we_n", 32'(sram_we_n), 1);
        check_eq("rst_addr", 32'(sram_addr), 0);
        check_eq("rst_wdata", 32'(sram_wdata), 0);
        check_eq("rst_write_done", 32'(write_done), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
        check_eq("rst_pix_count", 32'(pix_count), 0);

        // Single pixel into an idle writer: strobe timing relative to accept
        pix_valid = 1'b1;
        pix_addr  = 19'h0A0F0;
        pix_color = 8'h5A;
        model_offer(19'h0A0F0, 8'h5A);
        for (k = 0; k <= WE_CYCLES + 3; k++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            check_eq($sformatf("single_we_n_%0d", k), 32'(sram_we_n),
                     32'(!(k >= 2 && k < 2 + int'(WE_CYCLES))));
            check_eq($sformatf("single_ce_n_%0d", k), 32'(sram_ce_n),
                     32'(!(k >= 1 && k <= int'(WE_CYCLES) + 2)));
        end
        check_eq("single_pix_count", 32'(pix_count), 1);
        check_eq("single_writes", n_writes, 1);

        // Stream of 20 distinct pixels; producer pauses only while stop is high
        do_reset();
        pushes = 0; e = 0; first_occ = -1;
        while (pushes < 20 && e < 400) begin
            nxt = pushes;
            if (!stop) begin
                a = mk(int'($urandom_range(0, H_RES - 1)), pushes);
                pix_valid = 1'b1;
                pix_addr  = a;
                pix_color = COLOR_W'($urandom);
                model_offer(a, pix_color);
                nxt++;
            end else begin
                pix_valid = 1'b0;
            end
            @(negedge clk);
            pushes = nxt;
            // Writer never starves here: pops at 1, 1+P, 1+2P ... after the first push
            occ = pushes - ((e >= 1) ? ((e - 1) / P + 1) : 0);
            check_eq("stream_stop", 32'(stop), 32'(occ >= int'(DEPTH) - 2));
            if (stop && first_occ < 0) first_occ = occ;
            e++;
        end
        pix_valid = 1'b0;
        check_eq("stream_pushes", pushes, 20);
        check_eq("stream_stop_first_occ", first_occ, DEPTH - 2);
        wait_drain("stream");
        check_eq("stream_writes", n_writes, 20);
        check_eq("stream_pix_count", 32'(pix_count), 20);
        check_eq("stream_overflow", 32'(overflow), 0);

        // Clipped addresses: X=700, Y=500, wrapped X=0x3FF
        do_reset();
        stop_seen = 1'b0;
        present(mk(700, 10), 8'h11, 1'b0);
        present(mk(10, 500), 8'h22, 1'b0);
        present({10'h3FF, 9'd5}, 8'h33, 1'b0);
        for (k = 0; k < 10; k++) begin
            if (stop) stop_seen = 1'b1;
            @(negedge clk);
        end
        check_eq("clip_writes", n_writes, 0);
        check_eq("clip_pix_count", 32'(pix_count), 0);
        check_eq("clip_stop_seen", 32'(stop_seen), 0);

        // Duplicate address three times, then a new one
        do_reset();
        a = mk(100, 100);
        present(a, 8'hA1, 1'b1);
        present(a, 8'hA2, 1'b1);
        present(a, 8'hA3, 1'b1);
        present(mk(101, 100), 8'hB1, 1'b1);
        wait_drain("dedupe");
        check_eq("dedupe_writes", n_writes, 2);
        check_eq("dedupe_pix_count", 32'(pix_count), 2);

        // Eight pixels, prim_done pulse while writes are pending
        do_reset();
        for (k = 0; k < 8; k++) present(mk(200 + k, 50), COLOR_W'($urandom), 1'b1);
        prim_done = 1'b1;
        @(negedge clk);
        prim_done = 1'b0;
        got_done = 1'b0;
        g = 0;
        while (g < 300) begin
            if (write_done && !got_done) begin
                got_done = 1'b1;
                check_eq("done_writes", n_writes, 8);
                check_eq("done_queue_empty", exp_q.size(), 0);
                check_eq("done_ce_n", 32'(sram_ce_n), 1);
                check_eq("done_pix_count", 32'(pix_count), 8);
                @(negedge clk);
                g++;
                check_eq("done_pulse_len", 32'(write_done), 0);
                check_eq("done_pix_count_clr", 32'(pix_count), 0);
            end
            @(negedge clk);
            g++;
        end
        check_eq("done_seen", 32'(got_done), 1);
        check_eq("done_pulses", n_done, 1);

        // Random mix of visible, clipped and repeated pixels with valid gaps
        do_reset();
        prev_a = mk(0, 0);
        for (k = 0; k < 200; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 8)       a = mk(int'($urandom_range(H_RES, 1023)), int'($urandom_range(0, 511)));
            else if (r < 15) a = mk(int'($urandom_range(0, 1023)), int'($urandom_range(V_RES, 511)));
            else if (r < 35) a = prev_a;
            else             a = mk(int'($urandom_range(0, H_RES - 1)), int'($urandom_range(0, V_RES - 1)));
            prev_a = a;
            if ($urandom_range(0, 9) < 3) @(negedge clk);
            present(a, COLOR_W'($urandom), 1'b1);
        end
        wait_drain("random");
        check_eq("random_writes", n_writes, m_expected);
        check_eq("random_pix_count", 32'(pix_count), 32'(m_expected));
        check_eq("random_overflow", 32'(overflow), 0);
        prim_done = 1'b1;
        repeat (3) @(negedge clk);
        prim_done = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("random_done_pulses", n_done, 1);
        check_eq("random_pix_count_clr", 32'(pix_count), 0);

        // Ignore stop with 12 pixels, then reset in the middle of a strobe
        do_reset();
        for (k = 0; k < 12; k++) present(mk(300 + k, 7), COLOR_W'($urandom), 1'b0);
        g = 0;
        while (!(n_writes >= 9 && !sram_we_n) && g < 400) begin
            @(negedge clk);
            g++;
        end
        check_eq("ovf_wait_timeout", 32'(g < 400), 1);
        check_eq("ovf_overflow", 32'(overflow), 1);
        check_eq("ovf_min_writes", 32'(n_writes >= 8), 1);
        #1;
        n_rst = 1'b0;
        #1;
        check_eq("rst_mid_we_n", 32'(sram_we_n), 1);
        check_eq("rst_mid_ce_n", 32'(sram_ce_n), 1);
        check_eq("rst_mid_overflow", 32'(overflow), 0);
        check_eq("rst_mid_pix_count", 32'(pix_count), 0);
        check_eq("rst_mid_stop", 32'(stop), 0);
        repeat (2) @(negedge clk);
        exp_q.delete();
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("post_rst_ce_n", 32'(sram_ce_n), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
